jt4701_quadn: RTL and testbench
===============================

// Module: jt4701_quadn
// PURPOSE
// - Parametrised N-channel quadrature (dial/trackball) counter; successor of the single-chip uPD4701A-style counter.
// - Each channel counts every Gray-code transition of its A/B pair (x4 decode), glitch-filtered.
// - A read snapshot latches all channels when the CPU starts a read, so the two byte reads never tear.
// - Sits between the game-board CPU bus and the dial/mouse emulation or the raw encoder inputs.
// PARAMETERS
// - CH      2   number of channels, 1..8
// - CW      12  counter width, 9..13 (upper byte carries CW-8 count bits)
// - FILTER  3   cycles an input pair must be stable before it is accepted; 0 = no filter
// - SW      localparam = (CH>1 ? $clog2(CH) : 1), width of ch_sel
// PORTS
// - clk     in   1       system clock
// - rstn    in   1       asynchronous reset, active low
// - qa      in   CH      phase A per channel (asynchronous)
// - qb      in   CH      phase B per channel (asynchronous)
// - ch_rst  in   CH      synchronous per-channel clear, active high
// - csn     in   1       chip select, active low
// - uln     in   1       1 = upper byte, 0 = lower byte
// - ch_sel  in   SW      channel to read
// - dout    out  8       read data (registered)
// - cfn     out  1       counter flag, low when any channel has counted since its last read
// - dir     out  1       last count direction of the selected channel, 1 = up
// BEHAVIOUR
// - Reset (rstn=0): all counters, snapshots, flags, err bits, filters and synchronisers 0; dout=0, cfn=1, dir=0.
// - Input path per channel: 2-FF synchroniser -> stability filter -> decoder.
// - Filter: the accepted pair {A,B} changes only after the synchronised pair holds the same new value for FILTER consecutive cycles.
// - Decoder: compares the accepted pair with the previous accepted pair, once per clock.
//   - Up sequence 00->10->11->01->00 (A leads): count+1, dir=1.
//   - Down sequence 00->01->11->10->00: count-1, dir=0.
//   - Both bits changed: illegal; no count, set sticky err bit for the channel.
// - Latency: an input edge changes the count 3+FILTER cycles after it reaches qa/qb.
// - Counter arithmetic is modulo 2^CW: 0-1 = 2^CW-1, (2^CW-1)+1 = 0.
// - Channel flag is set on every count change.
//   - It clears on the csn rising edge (read done).
//   - Set wins over a clear in the same cycle.
// - cfn = ~|flags, registered.
// - Snapshot: on the csn falling edge, all CH counters are copied into snapshot registers in the same cycle.
//   - A count change in that same cycle is not captured; it appears in the next snapshot.
// - Read data, registered, one cycle after the ch_sel/uln change:
//   - lower byte: snap[ch_sel][7:0].
//   - upper byte: {err, flag, dir, snap[ch_sel][CW-1:8] zero-extended to 5 bits}.
//   - While csn=1, dout keeps its last value.
//   - ch_sel >= CH reads 0.
// - err clears when a csn rising edge ends an upper-byte read of that channel.
// - ch_rst[i]: synchronous clear of count, flag, err, dir and snapshot[i] next cycle; wins over a simultaneous count.
// - Channel states are independent; simultaneous counts on several channels are all applied.
// - rstn asserted mid-read: everything returns to reset values immediately; the first post-reset read returns 0.
// CONFIGURATION
// - Macro JTFRAME_QUADCNT_SAT_EN.
// - Defined: counters saturate instead of wrapping.
//   - Count held at 2^CW-1 on up and at 0 on down.
//   - dir still updates; flag is not set when the count is held.
// - Undefined: modulo-2^CW wrap as above.
// TESTING
// - CH=2, CW=12, FILTER=3; 4 up steps on ch0 -> count 4; csn low, uln=0 -> dout=8'h04; upper byte -> 8'h20 (err=0, flag=0, dir=1); cfn=0 before the read, 1 after csn rises.
// - ch1 at 0, one down step -> reads 12'hFFF (lower 8'hFF, upper bits[4:0]=5'h0F); with JTFRAME_QUADCNT_SAT_EN it stays 0 and flag stays 0.
// - 2-cycle glitch on qa with FILTER=3 -> no count change, no flag; 4-cycle pulse -> count +1 then -1.
// - Both qa and qb toggle in one cycle -> count unchanged, err=1 in upper byte; err cleared after that read.
// - ch0 steps during a lower-byte read -> the upper read of the same transaction matches the snapshot value; the next read shows the new count.
// - ch_rst[0] pulsed in the same cycle as a decoded step -> count 0, flag 0; rstn pulled low mid-read -> dout=0, cfn=1.

Source files
------------

// File: rtl/jt4701_quadn.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jt4701_quadn : N-channel x4 quadrature counter with glitch filter and a
// tear-free read snapshot. Define JTFRAME_QUADCNT_SAT_EN to saturate counts.
// Rev 1.0
// ---------------------------------------------------------------------------
module jt4701_quadn #(
  parameter int CH     = 2,
  parameter int CW     = 12,
  parameter int FILTER = 3,
  localparam int SW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CH-1:0] qa,
  input  logic [CH-1:0] qb,
  input  logic [CH-1:0] ch_rst,
  input  logic          csn,
  input  logic          uln,
  input  logic [SW-1:0] ch_sel,
  output logic [7:0]    dout,
  output logic          cfn,
  output logic          dir
);

`ifdef JTFRAME_QUADCNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [1:0]    r_s1   [CH];
  logic [1:0]    r_s2   [CH];
  logic [1:0]    r_prev [CH];
  logic [1:0]    w_acc  [CH];
  logic [CW-1:0] r_cnt  [CH];
  logic [CW-1:0] r_snap [CH];
  logic [CW-1:0] w_nxt  [CH];
  logic [CH-1:0] r_flag, r_err, r_dir;
  logic [CH-1:0] w_up, w_dn, w_bad, w_chg;
  logic          r_csn, r_rd_up, r_cfn, r_dir_o;
  logic [SW-1:0] r_rd_ch;
  logic [7:0]    r_dout;
  logic          w_fall, w_rise;
  logic [CW-1:0] w_src;
  logic          w_err_s, w_flag_s, w_dir_s;

  assign w_fall = ~csn & r_csn;
  assign w_rise = csn & ~r_csn;

  // Position of {A,B} along the up sequence 00,10,11,01
  function automatic logic [1:0] gidx(input logic [1:0] v);
    return {v[0], v[1] ^ v[0]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      if (FILTER > 0) begin : g_filt
        localparam int FW = $clog2(FILTER + 1) + 1;
        logic [1:0]    r_acc, r_cand;
        logic [FW-1:0] r_fcnt;
        logic [FW-1:0] w_held;
        assign w_held = (r_s2[gi] == r_cand) ? r_fcnt + 1'b1 : FW'(1);
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            r_acc  <= 2'b00;
            r_cand <= 2'b00;
            r_fcnt <= '0;
          end else begin
            r_cand <= r_s2[gi];
            if (r_s2[gi] == r_acc) begin
              r_fcnt <= '0;
            end else if (w_held >= FW'(FILTER)) begin
              r_acc  <= r_s2[gi];
              r_fcnt <= '0;
            end else begin
              r_fcnt <= w_held;
            end
          end
        end
        assign w_acc[gi] = r_acc;
      end else begin : g_nofilt
        assign w_acc[gi] = r_s2[gi];
      end
    end
  endgenerate

  always_comb begin
    w_up  = '0;
    w_dn  = '0;
    w_bad = '0;
    w_chg = '0;
    for (int i = 0; i < CH; i++) begin
      w_nxt[i] = r_cnt[i];
      case (gidx(w_acc[i]) - gidx(r_prev[i]))
        2'd1:    w_up[i]  = 1'b1;
        2'd3:    w_dn[i]  = 1'b1;
        2'd2:    w_bad[i] = 1'b1;
        default: ;
      endcase
      if (w_up[i] && !(SAT && r_cnt[i] == '1)) begin
        w_nxt[i] = r_cnt[i] + 1'b1;
        w_chg[i] = 1'b1;
      end else if (w_dn[i] && !(SAT && r_cnt[i] == '0)) begin
        w_nxt[i] = r_cnt[i] - 1'b1;
        w_chg[i] = 1'b1;
      end
    end
  end

  // On the snapshot cycle read straight from the counter so data is valid one cycle after csn falls
  always_comb begin
    w_src    = '0;
    w_err_s  = 1'b0;
    w_flag_s = 1'b0;
    w_dir_s  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (ch_sel == SW'(i)) begin
        w_src    = w_fall ? r_cnt[i] : r_snap[i];
        w_err_s  = r_err[i];
        w_flag_s = r_flag[i];
        w_dir_s  = r_dir[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        r_s1[i]   <= 2'b00;
        r_s2[i]   <= 2'b00;
        r_prev[i] <= 2'b00;
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
      r_flag  <= '0;
      r_err   <= '0;
      r_dir   <= '0;
      r_csn   <= 1'b1;
      r_rd_up <= 1'b0;
      r_rd_ch <= '0;
      r_dout  <= 8'h00;
      r_cfn   <= 1'b1;
      r_dir_o <= 1'b0;
    end else begin
      r_csn   <= csn;
      r_cfn   <= ~|r_flag;
      r_dir_o <= w_dir_s;
      if (!csn) begin
        r_rd_up <= uln;
        r_rd_ch <= ch_sel;
        r_dout  <= uln ? {w_err_s, w_flag_s, w_dir_s, 5'(w_src[CW-1:8])} : w_src[7:0];
      end
      for (int i = 0; i < CH; i++) begin
        r_s1[i]   <= {qa[i], qb[i]};
        r_s2[i]   <= r_s1[i];
        r_prev[i] <= w_acc[i];
        if (ch_rst[i]) begin
          r_cnt[i]  <= '0;
          r_snap[i] <= '0;
          r_flag[i] <= 1'b0;
          r_err[i]  <= 1'b0;
          r_dir[i]  <= 1'b0;
        end else begin
          r_cnt[i] <= w_nxt[i];
          if (w_up[i] || w_dn[i])
            r_dir[i] <= w_up[i];
          if (w_chg[i])
            r_flag[i] <= 1'b1;
          else if (w_rise)
            r_flag[i] <= 1'b0;
          if (w_bad[i])
            r_err[i] <= 1'b1;
          else if (w_rise && r_rd_up && r_rd_ch == SW'(i))
            r_err[i] <= 1'b0;
          if (w_fall)
            r_snap[i] <= r_cnt[i];
        end
      end
    end
  end

  assign dout = r_dout;
  assign cfn  = r_cfn;
  assign dir  = r_dir_o;

endmodule
`default_nettype wire

// File: tb/tb_jt4701_quadn.sv
`default_nettype none
// tb_jt4701_quadn : directed self-checking bench for jt4701_quadn (CH=2, CW=12, FILTER=3).
module tb_jt4701_quadn;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic [1:0] qa     = 2'b00;
  logic [1:0] qb     = 2'b00;
  logic [1:0] ch_rst = 2'b00;
  logic       csn    = 1'b1;
  logic       uln    = 1'b0;
  logic [0:0] ch_sel = 1'b0;
  logic [7:0] dout;
  logic       cfn, dir;
  logic [7:0] d;
  int         n_cmp = 0;
  int         n_err = 0;

`ifdef JTFRAME_QUADCNT_SAT_EN
  localparam logic [7:0] C1_LO  = 8'h00;
  localparam logic [7:0] C1_HI  = 8'h00;
  localparam logic [7:0] C1_CFN = 8'h01;
`else
  localparam logic [7:0] C1_LO  = 8'hFF;
  localparam logic [7:0] C1_HI  = 8'h0F;
  localparam logic [7:0] C1_CFN = 8'h00;
`endif

  always #5 clk = ~clk;

  jt4701_quadn #(.CH(2), .CW(12), .FILTER(3)) u_dut (
    .clk    (clk),
    .rstn   (rstn),
    .qa     (qa),
    .qb     (qb),
    .ch_rst (ch_rst),
    .csn    (csn),
    .uln    (uln),
    .ch_sel (ch_sel),
    .dout   (dout),
    .cfn    (cfn),
    .dir    (dir)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int sel, input logic up, output logic [7:0] data);
    csn    = 1'b0;
    uln    = up;
    ch_sel = sel[0:0];
    tick(2);
    data = dout;
    csn  = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("reset_dout", dout, 8'h00);
    chk("reset_cfn", {7'd0, cfn}, 8'h01);
    chk("reset_dir", {7'd0, dir}, 8'h00);
    rstn = 1'b1;
    tick(2);

    // four up steps on ch0: 00->10->11->01->00
    qa[0] = 1'b1; tick(8);
    qb[0] = 1'b1; tick(8);
    qa[0] = 1'b0; tick(8);
    qb[0] = 1'b0; tick(10);
    chk("up_cfn_before", {7'd0, cfn}, 8'h00);
    chk("up_dir", {7'd0, dir}, 8'h01);
    rd(0, 1'b0, d);
    chk("up_lo", d, 8'h04);
    chk("up_cfn_after", {7'd0, cfn}, 8'h01);
    rd(0, 1'b1, d);
    chk("up_hi", d, 8'h20);

    // one down step on ch1: 00->01
    qb[1] = 1'b1; tick(10);
    chk("dn_cfn", {7'd0, cfn}, C1_CFN);
    rd(1, 1'b0, d);
    chk("dn_lo", d, C1_LO);
    rd(1, 1'b1, d);
    chk("dn_hi", d, C1_HI);

    // 2-cycle glitch is rejected
    qa[0] = 1'b1; tick(2);
    qa[0] = 1'b0; tick(10);
    chk("glitch_cfn", {7'd0, cfn}, 8'h01);
    rd(0, 1'b0, d);
    chk("glitch_lo", d, 8'h04);

    // 4-cycle pulse: +1 then -1
    qa[0] = 1'b1; tick(4);
    qa[0] = 1'b0; tick(10);
    chk("pulse_cfn", {7'd0, cfn}, 8'h00);
    chk("pulse_dir", {7'd0, dir}, 8'h00);
    rd(0, 1'b0, d);
    chk("pulse_lo", d, 8'h04);

    // illegal double transition 00->11
    qa[0] = 1'b1; qb[0] = 1'b1; tick(10);
    chk("bad_cfn", {7'd0, cfn}, 8'h01);
    rd(0, 1'b1, d);
    chk("bad_hi_err", d, 8'h80);
    rd(0, 1'b1, d);
    chk("bad_hi_clr", d, 8'h00);
    rd(0, 1'b0, d);
    chk("bad_lo", d, 8'h04);

    // step (11->01) during a read transaction
    csn = 1'b0; uln = 1'b0; ch_sel = 1'b0;
    qa[0] = 1'b0;
    tick(2);
    chk("tear_lo_first", dout, 8'h04);
    tick(8);
    chk("tear_lo_again", dout, 8'h04);
    uln = 1'b1;
    tick(2);
    chk("tear_hi", dout, 8'h60);
    csn = 1'b1;
    tick(2);
    rd(0, 1'b0, d);
    chk("tear_next_lo", d, 8'h05);

    // ch_rst coincides with the decoded step 01->00
    qb[0] = 1'b0;
    tick(5);
    ch_rst[0] = 1'b1;
    tick(1);
    ch_rst[0] = 1'b0;
    tick(2);
    chk("chrst_cfn", {7'd0, cfn}, 8'h01);
    chk("chrst_dir", {7'd0, dir}, 8'h00);
    rd(0, 1'b0, d);
    chk("chrst_lo", d, 8'h00);

    // rstn asserted mid-read
    qa[0] = 1'b1; tick(10);
    csn = 1'b0; uln = 1'b0; ch_sel = 1'b0;
    tick(2);
    chk("rrd_lo", dout, 8'h01);
    rstn = 1'b0;
    #1;
    chk("rrd_dout", dout, 8'h00);
    chk("rrd_cfn", {7'd0, cfn}, 8'h01);
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    chk("rrd_post", dout, 8'h00);
    csn = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
